// File: rtl/pipe_stage_skid_if.sv
// Valid/ready payload bundle for one side of a pipeline stage.
// The master drives valid/data/ctrl; the slave returns ready.
interface pipe_stage_skid_if #(
    parameter int unsigned DATA_W = 160,
    parameter int unsigned CTRL_W = 16
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, output data, output ctrl, input ready);
    modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, synchronous flush,
// optional one-entry skid buffer and a saturating back-pressure counter.
module pipe_stage_skid #(
    parameter int unsigned DATA_W     = 160,
    parameter int unsigned CTRL_W     = 16,
    parameter bit          SKID_EN    = 1'b1,
    parameter bit          CLEAR_DATA = 1'b1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    pipe_stage_skid_if.slave     in_if,
    pipe_stage_skid_if.master    out_if,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     stall_cnt
);

    // Encoding equals the number of held entries so occupancy is a direct copy.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic out_valid_c;
    logic in_ready_c;
    logic in_fire_c;
    logic out_fire_c;
    logic load_main_in_c;
    logic load_main_skid_c;
    logic load_skid_c;

    // Handshake qualification; with the skid buffer, ready never looks at out_ready.
    always_comb begin
        out_valid_c = (state_q != ST_EMPTY);
        if (SKID_EN) begin
            in_ready_c = ~rst & (state_q != ST_TWO);
        end else begin
            in_ready_c = ~rst & (~out_valid_c | out_if.ready);
        end
        in_fire_c  = in_if.valid & in_ready_c & ~flush;
        out_fire_c = out_valid_c & out_if.ready;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush empties the stage regardless of the handshake.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire_c) state_d = ST_ONE;
                end
                ST_ONE: begin
                    if (in_fire_c && !out_fire_c && SKID_EN) begin
                        state_d = ST_TWO;
                    end else if (!in_fire_c && out_fire_c) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire_c) state_d = ST_ONE;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Output/datapath control: which entry loads from where this cycle.
    always_comb begin
        load_main_in_c   = 1'b0;
        load_main_skid_c = 1'b0;
        load_skid_c      = 1'b0;
        main_data_d      = main_data_q;
        main_ctrl_d      = main_ctrl_q;
        skid_data_d      = skid_data_q;
        skid_ctrl_d      = skid_ctrl_q;

        unique case (state_q)
            ST_EMPTY: load_main_in_c = in_fire_c;
            ST_ONE: begin
                load_main_in_c = in_fire_c & out_fire_c;
                load_skid_c    = in_fire_c & ~out_fire_c & SKID_EN;
            end
            ST_TWO:  load_main_skid_c = out_fire_c & ~flush;
            default: ;
        endcase

        if (load_main_in_c) begin
            main_data_d = in_if.data;
            main_ctrl_d = in_if.ctrl;
        end else if (load_main_skid_c) begin
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
        end

        if (load_skid_c) begin
            skid_data_d = in_if.data;
            skid_ctrl_d = in_if.ctrl;
        end

        // An empty main slot is a bubble: control always clears, data only if asked.
        if (state_d == ST_EMPTY) begin
            main_ctrl_d = '0;
            if (CLEAR_DATA) main_data_d = '0;
        end
    end

    // Back-pressure counter saturates at all-ones; flush cycles are not counted.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_c && !out_if.ready && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign in_if.ready  = in_ready_c;
    assign out_if.valid = out_valid_c;
    assign out_if.data  = main_data_q;
    assign out_if.ctrl  = main_ctrl_q;
    assign occupancy    = 2'(state_q);
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench: two stage instances (skid / pass-through) share stimulus; each has its own
// FIFO reference model, pushed by the driver and popped/compared by the monitor.
module tb_pipe_stage_skid;

    localparam int unsigned DATA_W = 160;
    localparam int unsigned CTRL_W = 16;
    localparam int unsigned ENT_W  = DATA_W + CTRL_W;
    localparam int          NCYC   = 700;

    typedef logic [ENT_W-1:0] ent_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic drv_valid;
    logic drv_ready;
    logic [DATA_W-1:0] drv_data;
    logic [CTRL_W-1:0] drv_ctrl;

    always #5 clk = ~clk;

    pipe_stage_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) in0 ();
    pipe_stage_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) out0 ();
    pipe_stage_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) in1 ();
    pipe_stage_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) out1 ();

    logic [1:0]  occ0, occ1;
    logic [3:0]  sc0;
    logic [15:0] sc1;

    pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID_EN(1'b1),
                      .CLEAR_DATA(1'b1), .CNT_W(4)) u_skid (
        .clk(clk), .rst(rst), .flush(flush), .in_if(in0), .out_if(out0),
        .occupancy(occ0), .stall_cnt(sc0));

    pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID_EN(1'b0),
                      .CLEAR_DATA(1'b0), .CNT_W(16)) u_pass (
        .clk(clk), .rst(rst), .flush(flush), .in_if(in1), .out_if(out1),
        .occupancy(occ1), .stall_cnt(sc1));

    assign in0.valid = drv_valid;
    assign in0.data  = drv_data;
    assign in0.ctrl  = drv_ctrl;
    assign out0.ready = drv_ready;
    assign in1.valid = drv_valid;
    assign in1.data  = drv_data;
    assign in1.ctrl  = drv_ctrl;
    assign out1.ready = drv_ready;

    logic              obs_in_ready [2];
    logic              obs_out_valid[2];
    logic [DATA_W-1:0] obs_data     [2];
    logic [CTRL_W-1:0] obs_ctrl     [2];
    logic [1:0]        obs_occ      [2];
    logic [15:0]       obs_cnt      [2];

    assign obs_in_ready[0]  = in0.ready;
    assign obs_in_ready[1]  = in1.ready;
    assign obs_out_valid[0] = out0.valid;
    assign obs_out_valid[1] = out1.valid;
    assign obs_data[0]      = out0.data;
    assign obs_data[1]      = out1.data;
    assign obs_ctrl[0]      = out0.ctrl;
    assign obs_ctrl[1]      = out1.ctrl;
    assign obs_occ[0]       = occ0;
    assign obs_occ[1]       = occ1;
    assign obs_cnt[0]       = 16'(sc0);
    assign obs_cnt[1]       = sc1;

    // Reference model: instance 0 holds up to two entries, instance 1 at most one.
    ent_t sbq[2][$];
    int   mcnt[2];
    ent_t last_main[2];
    bit   fire[2];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    function automatic int cap(int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic int cnt_max(int d);
        return (d == 0) ? 15 : 65535;
    endfunction

    function automatic ent_t pattern(logic [7:0] b);
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] dd;
        c  = {2{b}};
        dd = {20{b}};
        return {c, dd};
    endfunction

    task automatic chk(string name, int d, ent_t act, ent_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", name, d, cyc, act, exp);
        end
    endtask

    task automatic set_entry(ent_t e);
        drv_ctrl = e[ENT_W-1 -: CTRL_W];
        drv_data = e[DATA_W-1:0];
    endtask

    // Driver: stimulus at negedge, ready check, then enqueue accepted entries.
    initial begin
        rst = 1'b1; flush = 1'b0; drv_valid = 1'b1; drv_ready = 1'b0;
        drv_data = '0; drv_ctrl = '0;
        for (int d = 0; d < 2; d++) begin
            mcnt[d] = 0;
            last_main[d] = '0;
        end
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            cyc   = c;
            rst   = 1'b0;
            flush = 1'b0;
            if (c < 2) begin
                rst = 1'b1; drv_valid = 1'b1; drv_ready = 1'b0;
                set_entry(pattern(8'hEE));
            end else if (c < 8) begin
                drv_valid = (c < 5); drv_ready = 1'b1;
                set_entry(pattern(8'(8'h11 * (c - 1))));
            end else if (c < 16) begin
                drv_valid = (c < 10); drv_ready = (c >= 12);
                set_entry(pattern((c == 8) ? 8'hA1 : 8'hB2));
            end else if (c < 20) begin
                drv_valid = (c < 19); drv_ready = 1'b0; flush = (c == 18);
                set_entry(pattern((c == 18) ? 8'hDD : 8'(8'h40 + c)));
            end else if (c < 44) begin
                drv_valid = (c == 20); drv_ready = 1'b0;
                set_entry(pattern(8'h5A));
            end else begin
                rst       = ($urandom_range(99) == 0);
                flush     = ($urandom_range(99) < 5);
                drv_valid = ($urandom_range(99) < 70);
                drv_ready = ($urandom_range(99) < 60);
                drv_data  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
                drv_ctrl  = CTRL_W'($urandom());
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                bit exp_rdy;
                if (d == 0) exp_rdy = !rst && (sbq[d].size() < cap(d));
                else        exp_rdy = !rst && (sbq[d].size() == 0 || drv_ready);
                chk("in_ready", d, ent_t'(obs_in_ready[d]), ent_t'(exp_rdy));
                fire[d] = drv_valid && exp_rdy && !flush;
            end
            if (c == 43) chk("stall_sat", 0, ent_t'(obs_cnt[0]), ent_t'(15));
            #2;
            for (int d = 0; d < 2; d++) begin
                if (rst || flush) sbq[d].delete();
                else if (fire[d]) sbq[d].push_back({drv_ctrl, drv_data});
                if (rst) last_main[d] = '0;
                else if (sbq[d].size() > 0) last_main[d] = sbq[d][0];
            end
        end
        @(negedge clk);
        #4;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Monitor: compares the presented slot against the queue head, pops on consumption.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            for (int d = 0; d < 2; d++) begin
                int n;
                n = sbq[d].size();
                chk("out_valid", d, ent_t'(obs_out_valid[d]), ent_t'(n > 0));
                chk("occupancy", d, ent_t'(obs_occ[d]), ent_t'(n));
                chk("stall_cnt", d, ent_t'(obs_cnt[d]), ent_t'(mcnt[d]));
                if (n > 0) begin
                    ent_t head;
                    head = sbq[d][0];
                    chk("out_data", d, ent_t'(obs_data[d]), ent_t'(head[DATA_W-1:0]));
                    chk("out_ctrl", d, ent_t'(obs_ctrl[d]), ent_t'(head[ENT_W-1 -: CTRL_W]));
                    if (drv_ready) void'(sbq[d].pop_front());
                end else begin
                    ent_t lm;
                    lm = last_main[d];
                    chk("bubble_ctrl", d, ent_t'(obs_ctrl[d]), '0);
                    chk("bubble_data", d, ent_t'(obs_data[d]),
                        (d == 0) ? '0 : ent_t'(lm[DATA_W-1:0]));
                end
                if (rst) mcnt[d] = 0;
                else if (n > 0 && !drv_ready && !flush && mcnt[d] < cnt_max(d)) mcnt[d]++;
            end
        end
    end

endmodule
